regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 60 ++++++
 tb/tb_regfile_mp.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file, x0 hardwired to zero, per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for a write-through bypass from the write port to the read ports.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRP  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRP*AW-1:0]     rd_addr,
  output logic [NRP*XLEN-1:0]   rd_data,
  output logic [NRP-1:0]        rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic [NREG-1:0]       busy_vec,
  output logic                  any_busy,
  output logic [15:0]           wr_cnt
);
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic            wr_ok, rsv_ok;
  assign wr_ok  = we && (wa != '0);
  assign rsv_ok = rsv_en && (rsv_addr != '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '{default: '0};
    else if (wr_ok) mem[wa] <= wd;
  // reserve is applied after the write clear so a same-address reserve keeps the register busy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy   <= '0;
      wr_cnt <= '0;
    end else begin
      if (wr_ok) begin
        busy[wa] <= 1'b0;
        wr_cnt   <= wr_cnt + 16'd1;
      end
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
    end
  assign busy_vec = busy & ~NREG'(1);
  assign any_busy = |busy_vec;
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] stored;
    assign a      = rd_addr[p*AW +: AW];
    assign stored = (a == '0) ? '0 : mem[a];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit                     = wr_ok && (wa == a);
    assign rd_data[p*XLEN +: XLEN] = hit ? wd : stored;
    assign rd_busy[p]              = hit ? (rsv_ok && (rsv_addr == wa)) : busy_vec[a];
`else
    assign rd_data[p*XLEN +: XLEN] = stored;
    assign rd_busy[p]              = busy_vec[a];
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table, hand corner sequences and randomized model check for regfile_mp.
module tb_regfile_mp;
  localparam int XLEN = 32, NREG = 32, AW = 5, NRP = 2;
  logic clk = 1'b0, rst;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                we, rsv_en, any_busy;
  logic [AW-1:0]       wa, rsv_addr;
  logic [XLEN-1:0]     wd;
  logic [NREG-1:0]     busy_vec;
  logic [15:0]         wr_cnt;
  int checks = 0, failures = 0;
  logic [XLEN-1:0] m_reg [NREG];
  logic            m_busy [NREG];
  logic [15:0]     m_cnt;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic w; logic [4:0] a; logic [31:0] d; logic r; logic [4:0] ra;
    logic [4:0] a0, a1; logic [31:0] d0, d1; logic b0, b1, any; logic [15:0] cnt;
  } vec_t;
  vec_t tbl [11];
  always #5 clk = ~clk;
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(busy_vec), .any_busy(any_busy), .wr_cnt(wr_cnt)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                       input logic r, input logic [AW-1:0] ra, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    we = w; wa = a; wd = d; rsv_en = r; rsv_addr = ra; rd_addr = {a1, a0};
  endtask
  task automatic idle();
    we = 1'b0; rsv_en = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (BYP && we && wa != 0 && wa == a) return wd;
    return (a == 0) ? '0 : m_reg[a];
  endfunction
  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (BYP && we && wa != 0 && wa == a) return rsv_en && rsv_addr == wa;
    return (a == 0) ? 1'b0 : m_busy[a];
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
    m_cnt = '0;
  endtask
  task automatic model_step();
    if (we && wa != 0) begin m_reg[wa] = wd; m_busy[wa] = 1'b0; m_cnt = m_cnt + 16'd1; end
    if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
  endtask
  function automatic logic [AW-1:0] pick();
    return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 5)) : AW'($urandom_range(0, NREG - 1));
  endfunction
  initial begin
    logic [NREG-1:0] ev;
    logic [AW-1:0] a;
    tbl[0]  = '{1, 9, 'h40, 0, 0, 9, 6, 'h40, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 6, 'h30, 0, 0, 9, 6, 'h40, 'h30, 0, 0, 0, 2};
    tbl[2]  = '{0, 0, 0, 0, 0, 9, 9, 'h40, 'h40, 0, 0, 0, 2};
    tbl[3]  = '{0, 0, 0, 1, 7, 7, 0, 0, 0, 1, 0, 1, 2};
    tbl[4]  = '{1, 7, 'h70, 0, 0, 7, 9, 'h70, 'h40, 0, 0, 0, 3};
    tbl[5]  = '{1, 3, 'h33, 1, 3, 3, 7, 'h33, 'h70, 1, 0, 1, 4};
    tbl[6]  = '{1, 0, 'h1234, 1, 0, 0, 3, 0, 'h33, 0, 1, 1, 4};
    tbl[7]  = '{1, 3, 'h5, 0, 0, 3, 0, 'h5, 0, 0, 0, 0, 5};
    tbl[8]  = '{1, 11, 'hBB, 1, 10, 10, 11, 0, 'hBB, 1, 0, 1, 6};
    tbl[9]  = '{0, 0, 0, 1, 10, 10, 10, 0, 0, 1, 1, 1, 6};
    tbl[10] = '{1, 10, 'hAA, 0, 0, 10, 11, 'hAA, 'hBB, 0, 0, 0, 7};
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 5, 0);
    #12;
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_busy", rd_busy, 0);
    chk("reset_busy_vec", busy_vec, 0);
    chk("reset_any_busy", any_busy, 0);
    chk("reset_wr_cnt", wr_cnt, 0);
    rst = 1'b0;
    tick();
    drive(1, 5, 32'hDEAD_BEEF, 1, 8, 5, 0);
    tick();
    idle(); #1;
    chk("pre_rst_reg5", rd_data[31:0], 32'hDEAD_BEEF);
    chk("pre_rst_busy_vec", busy_vec, 32'h100);
    chk("pre_rst_wr_cnt", wr_cnt, 1);
    rst = 1'b1; #1;
    chk("async_rst_reg5", rd_data[31:0], 0);
    chk("async_rst_busy_vec", busy_vec, 0);
    chk("async_rst_wr_cnt", wr_cnt, 0);
    rst = 1'b0;
    drive(1, 0, 32'h1234, 0, 0, 0, 0);
    tick();
    idle(); #1;
    chk("x0_read", rd_data[31:0], 0);
    chk("x0_wr_cnt", wr_cnt, 0);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].r, tbl[i].ra, tbl[i].a0, tbl[i].a1);
      tick();
      idle(); #1;
      chk($sformatf("tbl%0d_d0", i), rd_data[31:0], tbl[i].d0);
      chk($sformatf("tbl%0d_d1", i), rd_data[63:32], tbl[i].d1);
      chk($sformatf("tbl%0d_b0", i), rd_busy[0], tbl[i].b0);
      chk($sformatf("tbl%0d_b1", i), rd_busy[1], tbl[i].b1);
      chk($sformatf("tbl%0d_any", i), any_busy, tbl[i].any);
      chk($sformatf("tbl%0d_cnt", i), wr_cnt, tbl[i].cnt);
    end
    drive(1, 4, 32'h44, 1, 4, 4, 4);
    tick();
    drive(1, 4, 32'hABCD, 0, 0, 4, 0); #1;
    chk("byp_same_cycle_data", rd_data[31:0], BYP ? 32'hABCD : 32'h44);
    chk("byp_same_cycle_busy", rd_busy[0], BYP ? 1'b0 : 1'b1);
    tick();
    idle(); #1;
    chk("byp_next_data", rd_data[31:0], 32'hABCD);
    chk("byp_next_busy", rd_busy[0], 0);
    drive(1, 4, 32'h55, 1, 4, 4, 0); #1;
    chk("byp_rsv_data", rd_data[31:0], BYP ? 32'h55 : 32'hABCD);
    chk("byp_rsv_busy", rd_busy[0], BYP ? 1'b1 : 1'b0);
    tick();
    idle(); #1;
    chk("byp_rsv_next_data", rd_data[31:0], 32'h55);
    chk("byp_rsv_next_busy", rd_busy[0], 1);
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      we = ($urandom_range(0, 2) != 0); wa = pick(); wd = $urandom;
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = ($urandom_range(0, 3) == 0) ? wa : pick();
      rd_addr = {pick(), ($urandom_range(0, 2) == 0) ? wa : pick()};
      #1;
      for (int p = 0; p < NRP; p++) begin
        a = rd_addr[p*AW +: AW];
        chk($sformatf("rand%0d_d%0d", i, p), rd_data[p*XLEN +: XLEN], exp_data(a));
        chk($sformatf("rand%0d_b%0d", i, p), rd_busy[p], exp_busy(a));
      end
      for (int r = 0; r < NREG; r++) ev[r] = m_busy[r];
      chk($sformatf("rand%0d_busy_vec", i), busy_vec, ev);
      chk($sformatf("rand%0d_any", i), any_busy, |ev);
      chk($sformatf("rand%0d_cnt", i), wr_cnt, m_cnt);
      @(posedge clk);
      model_step();
      #1;
    end
    idle();
    rst = 1'b1; #1; rst = 1'b0;
    drive(1, 1, 32'h11, 0, 0, 1, 0);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_pre_cnt", wr_cnt, 16'hFFFF);
    @(posedge clk); #1;
    idle();
    chk("wrap_cnt", wr_cnt, 16'h0000);
    chk("wrap_data", rd_data[31:0], 32'h11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
